// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//
// Sends one byte (8 data bits LSB first, odd parity, stop) to a PS/2 device
// over open-drain clock/data lines. The sequence is: inhibit the clock,
// request-to-send by pulling data low, then shift bits out on device-driven
// clock falling edges. The device ACK is sampled on the 11th falling edge.
//
// Optional build macro: PS2_TX_TIMEOUT_EN enables a watchdog that aborts the
// transfer (done with err=1) if the device has not finished TIMEOUT_CYCLES
// cycles after the host releases the clock.
//
// Ports:
//   pclk         in   clock, rising-edge
//   rst          in   asynchronous active-high reset
//   tx_data[7:0] in   byte to send, latched on accept
//   tx_valid     in   send request
//   tx_ready     out  high in IDLE; accept = tx_valid && tx_ready
//   ps2_clk_in   in   raw PS/2 clock pin level (asynchronous)
//   ps2_data_in  in   raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe   out  1 pulls the clock line low
//   ps2_data_oe  out  1 pulls the data line low
//   busy         out  high whenever not IDLE
//   done         out  one-cycle pulse at the end of a transfer
//   err          out  valid with done: 1 = NACK or timeout

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6500,
  parameter int unsigned REQ_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1300000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One counter times the inhibit/request phases and, when enabled, the
  // watchdog; those intervals never overlap, so it is sized for the largest.
  localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       n_q, n_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             nack_q, nack_d;
  logic [7:0]       tx_q, tx_d;
  logic             par_q, par_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic fe;
  logic [3:0] n_next;

  // Single-shot edge: one fe per sampled 1->0 transition of the synced clock.
  assign fe     = clk_prev_q & ~clk_s2_q;
  assign n_next = n_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = err_q;
    nack_d    = nack_q;
    tx_d      = tx_q;
    par_d     = par_q;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        cnt_d     = '0;
        if (tx_valid) begin
          tx_d     = tx_data;
          par_d    = ~^tx_data;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_REQ: begin
        if (cnt_q == REQ_LAST) begin
          // Data stays low as the start bit while the device starts clocking.
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          n_d      = '0;
          state_d  = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (fe) begin
          n_d = n_next;
          if (n_next <= 4'd8) begin
            data_oe_d = ~tx_q[n_q[2:0]];
          end else if (n_next == 4'd9) begin
            data_oe_d = ~par_q;
          end else if (n_next == 4'd10) begin
            data_oe_d = 1'b0;
          end else begin
            nack_d  = data_s2_q;
            state_d = S_WAIT_IDLE;
          end
        end
`ifdef PS2_TX_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          state_d   = S_WAIT_IDLE;
        end
`endif
      end

      S_WAIT_IDLE: begin
        // done is raised while still busy; IDLE (tx_ready) follows a cycle later.
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          if (clk_s2_q && data_s2_q) begin
            done_d = 1'b1;
            err_d  = nack_q;
          end
`ifdef PS2_TX_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TO_LAST) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
          end
`endif
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      // Synchronizers reset to the idle (released) line level.
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      n_q        <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      nack_q     <= nack_d;
    end
  end

  // Payload holds no control meaning, so it is not reset.
  always_ff @(posedge pclk) begin
    tx_q  <= tx_d;
    par_q <= par_d;
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 6500;
  localparam int REQ = 16;
  localparam int TO  = 2000;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       dev_clk = 1'b1;   // 1 = device releases clock
  logic       dev_data = 1'b1;  // 1 = device releases data
  logic       clk_pin, data_pin;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  // Open-drain wired-AND of host and device.
  assign clk_pin  = ~ps2_clk_oe & dev_clk;
  assign data_pin = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(clk_pin), .ps2_data_in(data_pin), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .err(err)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Reference frame: position 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic bit exp_bit(input logic [7:0] b, input int pos);
    int v, ones;
    v = b;
    if (pos <= 8) return bit'((v / (1 << (pos - 1))) % 2);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (v / (1 << i)) % 2;
    if (pos == 9) return (ones % 2 == 0) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  // One device clock pulse; samples the data pin just before the rising edge.
  task automatic dev_pulse(output bit samp);
    int lo, hi;
    lo = $urandom_range(8, 16);
    hi = $urandom_range(8, 16);
    dev_clk = 1'b0;
    repeat (lo) step();
    samp = data_pin;
    dev_clk = 1'b1;
    repeat (hi) step();
  endtask

  // Accept a byte and measure the clock-inhibit phase.
  task automatic start_send(input logic [7:0] b, input string tag);
    int k, hold;
    k = 0;
    while (tx_ready !== 1'b1 && k < 200) begin step(); k++; end
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready: got %b expected 1", tag, tx_ready); end
    tx_data = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    n_cmp++;
    if (ps2_clk_oe !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL %s_accept: clk_oe=%b busy=%b expected 1 1", tag, ps2_clk_oe, busy);
    end
    hold = 1;
    while (ps2_clk_oe === 1'b1 && hold < 20000) begin
      step();
      if (ps2_clk_oe === 1'b1) hold++;
    end
    n_cmp++;
    if (hold != INH + REQ) begin n_bad++; $display("FAIL %s_inhibit: got %0d cycles expected %0d", tag, hold, INH + REQ); end
    n_cmp++;
    if (ps2_data_oe !== 1'b1) begin n_bad++; $display("FAIL %s_start: data_oe=%b expected 1", tag, ps2_data_oe); end
    repeat (10) step();
  endtask

  task automatic do_send(input logic [7:0] b, input bit nack, input bit inject, input string tag);
    bit got [1:10];
    int d0, k;
    d0 = done_cnt;
    start_send(b, tag);
    for (int i = 1; i <= 10; i++) begin
      if (inject && i == 5) begin tx_valid = 1'b1; tx_data = 8'hFF; end
      dev_pulse(got[i]);
      tx_valid = 1'b0;
    end
    dev_data = nack;
    repeat (2) step();
    dev_clk = 1'b0;
    repeat (10) step();
    dev_clk = 1'b1;
    dev_data = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 100) begin step(); k++; end
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b expected 1", tag, done); end
    n_cmp++;
    if (err !== nack) begin n_bad++; $display("FAIL %s_err: got %b expected %b", tag, err, nack); end
    n_cmp++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_bad++; $display("FAIL %s_release: clk_oe=%b data_oe=%b expected 0 0", tag, ps2_clk_oe, ps2_data_oe);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s_after: done=%b tx_ready=%b expected 0 1", tag, done, tx_ready);
    end
    n_cmp++;
    if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL %s_pulses: got %0d expected 1", tag, done_cnt - d0); end
    for (int i = 1; i <= 10; i++) begin
      n_cmp++;
      if (got[i] !== exp_bit(b, i)) begin
        n_bad++; $display("FAIL %s_bit%0d: got %b expected %b", tag, i, got[i], exp_bit(b, i));
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: oe=%b%b done=%b err=%b busy=%b rdy=%b expected 00 0 0 0 1",
               ps2_clk_oe, ps2_data_oe, done, err, busy, tx_ready);
    end
    rst = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (busy !== 1'b0 || tx_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: busy=%b rdy=%b done=%b expected 0 1 0", busy, tx_ready, done);
    end
  endtask

  task automatic test_reset_mid();
    bit s;
    int d0;
    d0 = done_cnt;
    start_send(8'hA3, "rstmid");
    for (int i = 1; i <= 4; i++) dev_pulse(s);
    n_cmp++;
    if (ps2_data_oe !== ~exp_bit(8'hA3, 4)) begin
      n_bad++; $display("FAIL rstmid_pre: data_oe=%b expected %b", ps2_data_oe, ~exp_bit(8'hA3, 4));
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_async: oe=%b%b busy=%b rdy=%b expected 00 0 1", ps2_clk_oe, ps2_data_oe, busy, tx_ready);
    end
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (done_cnt != d0) begin n_bad++; $display("FAIL rstmid_nodone: got %0d pulses expected 0", done_cnt - d0); end
    do_send(8'hF4, 1'b0, 1'b0, "after_rst");
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    start_send(8'h3C, "timeout");
    // start_send returns 10 cycles after the clock release was first seen.
    k = 10;
    while (done !== 1'b1 && k < 5000) begin step(); k++; end
    n_cmp++;
    if (k != TO) begin n_bad++; $display("FAIL timeout_time: got %0d cycles expected %0d", k, TO); end
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_out: done=%b err=%b oe=%b%b expected 1 1 00", done, err, ps2_clk_oe, ps2_data_oe);
    end
    step();
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL timeout_ready: got %b expected 1", tx_ready); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] b;
    b = 8'($urandom);
    do_send(b, 1'($urandom), 1'b0, "b2b_a");
    b = 8'($urandom);
    do_send(b, 1'($urandom), 1'b0, "b2b_b");
  endtask

  initial begin
    #2;
    test_reset();
    do_send(8'hF4, 1'b0, 1'b0, "f4_ack");
    do_send(8'h00, 1'b0, 1'b0, "zero_ack");
    do_send(8'h55, 1'b1, 1'b0, "nack_55");
    test_reset_mid();
    do_send(8'h12, 1'b0, 1'b1, "ignore_valid");
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
